// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised oversampling UART receiver.
// Configurable data width, oversampling ratio, parity and stop bits. It resynchronises
// after a framing error by waiting for an idle line. The received word is held in a
// one-entry output register with a valid/ready handshake.
module uart_rx_cfg #(
    parameter int unsigned P_DATA_BITS = 8,
    parameter int unsigned P_OVS       = 16,
    parameter int unsigned P_PARITY    = 0,
    parameter int unsigned P_STOP_BITS = 2,
    parameter int unsigned P_IDLE_TH   = 160
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   serial_in,
    input  logic                   baud_tick,
    output logic [P_DATA_BITS-1:0] Do,
    output logic                   valid,
    input  logic                   ready,
    output logic                   frame_err,
    output logic                   parity_err,
    output logic                   overrun,
    output logic                   busy
);

    localparam int unsigned CNT_W  = $clog2(P_OVS);
    localparam int unsigned IDLE_W = $clog2(P_IDLE_TH + 1);
    localparam int unsigned BIT_W  = $clog2(P_DATA_BITS);

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDLE_W-1:0]      idle_q;
    logic [BIT_W-1:0]       bit_q;
    logic                   stop_q;
    logic [P_DATA_BITS-1:0] shreg_q;
    logic                   par_bad_q;
    logic                   busy_q;

    logic [1:0]             sync_q;
    logic                   line;

    logic [P_DATA_BITS-1:0] do_q;
    logic                   valid_q;
    logic                   frame_err_q;
    logic                   parity_err_q;
    logic                   overrun_q;

    logic                   at_half;
    logic                   at_full;
    logic                   last_stop;
    logic                   exp_par;
    logic                   stop_tick;
    logic                   done_ok;
    logic                   stop_bad;

    // Two-flop synchroniser for the asynchronous serial line; resets to the idle level.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], serial_in};
        end
    end

    assign line = sync_q[1];

    // Sample-point decode and frame completion/error events for the current tick.
    always_comb begin
        at_half   = (cnt_q == CNT_W'(P_OVS / 2 - 1));
        at_full   = (cnt_q == CNT_W'(P_OVS - 1));
        last_stop = (stop_q == 1'(P_STOP_BITS - 1));
        exp_par   = (P_PARITY == 1) ? ~(^shreg_q) : (^shreg_q);
        stop_tick = baud_tick && (state_q == ST_STOP) && at_full;
        done_ok   = stop_tick && line && last_stop;
        stop_bad  = stop_tick && !line;
    end

    // Receive FSM: advances on baud_tick only; busy is registered alongside the state.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= ST_SYNC;
            cnt_q     <= '0;
            idle_q    <= '0;
            bit_q     <= '0;
            stop_q    <= 1'b0;
            shreg_q   <= '0;
            par_bad_q <= 1'b0;
            busy_q    <= 1'b0;
        end else if (baud_tick) begin
            case (state_q)
                ST_SYNC: begin
                    if (!line) begin
                        idle_q <= '0;
                    end else if (idle_q == IDLE_W'(P_IDLE_TH - 1)) begin
                        idle_q  <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        idle_q <= idle_q + IDLE_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (!line) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (at_half) begin
                        cnt_q <= '0;
                        if (!line) begin
                            state_q   <= ST_DATA;
                            bit_q     <= '0;
                            par_bad_q <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (at_full) begin
                        cnt_q   <= '0;
                        shreg_q <= {line, shreg_q[P_DATA_BITS-1:1]};
                        if (bit_q == BIT_W'(P_DATA_BITS - 1)) begin
                            stop_q  <= 1'b0;
                            state_q <= (P_PARITY != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (at_full) begin
                        cnt_q     <= '0;
                        par_bad_q <= (line != exp_par);
                        stop_q    <= 1'b0;
                        state_q   <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (at_full) begin
                        cnt_q <= '0;
                        if (!line) begin
                            state_q <= ST_SYNC;
                            idle_q  <= '0;
                            busy_q  <= 1'b0;
                        end else if (last_stop) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            stop_q <= stop_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_SYNC;
                    cnt_q   <= '0;
                    idle_q  <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output register and handshake; error strobes are single-cycle pulses.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            do_q         <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_err_q  <= stop_bad;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            if (done_ok) begin
                if (!valid_q || ready) begin
                    do_q         <= shreg_q;
                    valid_q      <= 1'b1;
                    parity_err_q <= par_bad_q;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign Do         = do_q;
    assign valid      = valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg: four differently configured receivers, randomised frames,
// scoreboard of expected outputs drained by an independent monitor.
module tb_uart_rx_cfg;

    localparam int NI     = 4;
    localparam int IDLE_T = 200;
    localparam int NB  [NI] = '{8, 8, 7, 9};
    localparam int OVS [NI] = '{16, 16, 8, 6};
    localparam int PAR [NI] = '{0, 2, 0, 1};
    localparam int STP [NI] = '{2, 1, 2, 1};
    localparam int ITH [NI] = '{160, 160, 160, 20};

    localparam int K_WORD = 0;
    localparam int K_FE   = 1;
    localparam int K_OV   = 2;

    typedef struct {
        int         kind;
        logic [8:0] data;
        logic       perr;
    } ev_t;

    logic CLK       = 1'b0;
    logic reset     = 1'b1;
    logic baud_tick = 1'b0;
    logic ser [NI];
    logic rdy [NI];

    logic [7:0] do0, do1;
    logic [6:0] do2;
    logic [8:0] do3;
    logic [8:0] dout [NI];
    logic v [NI], fe [NI], pe [NI], ov [NI], bz [NI];

    ev_t expq [NI][$];
    bit  synced [NI];
    bit  occ [NI];
    logic pv [NI], pr [NI];

    int n_tests = 0;
    int n_fail  = 0;

    uart_rx_cfg #(.P_DATA_BITS(NB[0]), .P_OVS(OVS[0]), .P_PARITY(PAR[0]), .P_STOP_BITS(STP[0]), .P_IDLE_TH(ITH[0])) u_a (
        .CLK(CLK), .reset(reset), .serial_in(ser[0]), .baud_tick(baud_tick), .Do(do0), .valid(v[0]),
        .ready(rdy[0]), .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ov[0]), .busy(bz[0]));
    uart_rx_cfg #(.P_DATA_BITS(NB[1]), .P_OVS(OVS[1]), .P_PARITY(PAR[1]), .P_STOP_BITS(STP[1]), .P_IDLE_TH(ITH[1])) u_b (
        .CLK(CLK), .reset(reset), .serial_in(ser[1]), .baud_tick(baud_tick), .Do(do1), .valid(v[1]),
        .ready(rdy[1]), .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ov[1]), .busy(bz[1]));
    uart_rx_cfg #(.P_DATA_BITS(NB[2]), .P_OVS(OVS[2]), .P_PARITY(PAR[2]), .P_STOP_BITS(STP[2]), .P_IDLE_TH(ITH[2])) u_c (
        .CLK(CLK), .reset(reset), .serial_in(ser[2]), .baud_tick(baud_tick), .Do(do2), .valid(v[2]),
        .ready(rdy[2]), .frame_err(fe[2]), .parity_err(pe[2]), .overrun(ov[2]), .busy(bz[2]));
    uart_rx_cfg #(.P_DATA_BITS(NB[3]), .P_OVS(OVS[3]), .P_PARITY(PAR[3]), .P_STOP_BITS(STP[3]), .P_IDLE_TH(ITH[3])) u_d (
        .CLK(CLK), .reset(reset), .serial_in(ser[3]), .baud_tick(baud_tick), .Do(do3), .valid(v[3]),
        .ready(rdy[3]), .frame_err(fe[3]), .parity_err(pe[3]), .overrun(ov[3]), .busy(bz[3]));

    always_comb begin
        dout[0] = {1'b0, do0};
        dout[1] = {1'b0, do1};
        dout[2] = {2'b00, do2};
        dout[3] = do3;
    end

    // 10-unit clock; baud_tick is high every other cycle
    initial forever #5 CLK = ~CLK;
    initial forever begin
        @(negedge CLK);
        baud_tick = ~baud_tick;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
        $fatal(1);
    end

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0h, expected %0h at %0t", name, i, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic par_bit(input int i, input logic [8:0] d);
        int ones;
        ones = $countones(d);
        if (PAR[i] == 1) return logic'((ones % 2) == 0);
        return logic'((ones % 2) == 1);
    endfunction

    function automatic logic [8:0] mask_of(input int i);
        logic [8:0] m;
        m = 9'((1 << NB[i]) - 1);
        return m;
    endfunction

    task automatic predict(input int i, input logic [8:0] d, input bit bad_par, input bit bad_stop);
        ev_t e;
        e.data = d;
        e.perr = bad_par;
        if (!synced[i]) return;
        if (bad_stop) begin
            e.kind   = K_FE;
            synced[i] = 1'b0;
        end else if (occ[i]) begin
            e.kind = K_OV;
        end else begin
            e.kind = K_WORD;
            if (!rdy[i]) occ[i] = 1'b1;
        end
        expq[i].push_back(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            synced[i] = 1'b0;
            occ[i]    = 1'b0;
        end
    endtask

    // ---------------- line drivers (1 tick = 2 clocks) ----------------
    task automatic hold(input int n);
        repeat (2 * n) @(negedge CLK);
    endtask

    task automatic idle(input int n);
        hold(n);
        if (n >= IDLE_T) begin
            for (int i = 0; i < NI; i++) synced[i] = 1'b1;
        end
    endtask

    task automatic drive_frame(input int i, input logic [8:0] d, input bit bad_par, input bit bad_stop);
        ser[i] = 1'b0;
        hold(OVS[i]);
        for (int b = 0; b < NB[i]; b++) begin
            ser[i] = d[b];
            hold(OVS[i]);
        end
        if (PAR[i] != 0) begin
            ser[i] = par_bit(i, d) ^ bad_par;
            hold(OVS[i]);
        end
        for (int s = 0; s < STP[i]; s++) begin
            ser[i] = !bad_stop;
            hold(OVS[i]);
        end
        ser[i] = 1'b1;
    endtask

    task automatic send_frame(input int i, input logic [8:0] d, input bit bad_par, input bit bad_stop);
        logic [8:0] dm;
        dm = d & mask_of(i);
        predict(i, dm, bad_par, bad_stop);
        drive_frame(i, dm, bad_par, bad_stop);
    endtask

    // ---------------- monitor ----------------
    task automatic take(input int i, input int kind, output ev_t e);
        e.kind = -1;
        e.data = '0;
        e.perr = 1'b0;
        if (expq[i].size() > 0) e = expq[i].pop_front();
        check("event_kind", i, e.kind, kind);
    endtask

    task automatic mon_inst(input int i);
        ev_t e;
        bit  nw;
        nw = v[i] && (!pv[i] || pr[i]);
        if (fe[i]) take(i, K_FE, e);
        if (ov[i]) take(i, K_OV, e);
        if (nw) begin
            take(i, K_WORD, e);
            check("Do", i, dout[i], e.data);
            check("parity_err", i, pe[i], e.perr);
        end else if (pe[i]) begin
            check("parity_err_without_load", i, pe[i], 0);
        end
    endtask

    always begin
        @(posedge CLK);
        #1;
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                pv[i] = 1'b0;
                pr[i] = 1'b0;
            end else begin
                mon_inst(i);
                pv[i] = v[i];
                pr[i] = rdy[i];
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < NI; i++) begin
            ser[i] = 1'b1;
            rdy[i] = 1'b1;
            pv[i]  = 1'b0;
            pr[i]  = 1'b0;
        end
        model_reset();
        repeat (4) @(negedge CLK);
        for (int i = 0; i < NI; i++) begin
            check("rst_Do", i, dout[i], 0);
            check("rst_valid", i, v[i], 0);
            check("rst_busy", i, bz[i], 0);
            check("rst_errs", i, {fe[i], pe[i], ov[i]}, 0);
        end
        reset = 1'b0;
        idle(IDLE_T);

        // 8N2 basic frame, busy while receiving
        fork
            send_frame(0, 9'h0A5, 1'b0, 1'b0);
            begin
                hold(40);
                check("busy_mid_frame", 0, bz[0], 1);
            end
        join
        hold(20);
        check("busy_after_frame", 0, bz[0], 0);

        // 8E1: wrong then correct parity
        send_frame(1, 9'h03C, 1'b1, 1'b0);
        hold(4);
        send_frame(1, 9'h03C, 1'b0, 1'b0);
        hold(4);

        // stop bit low, then a frame without idle is ignored, then received after idle
        send_frame(0, 9'h055, 1'b0, 1'b1);
        send_frame(0, 9'h012, 1'b0, 1'b0);
        idle(IDLE_T);
        send_frame(0, 9'h012, 1'b0, 1'b0);
        hold(4);

        // overrun with ready low
        rdy[0] = 1'b0;
        send_frame(0, 9'h001, 1'b0, 1'b0);
        send_frame(0, 9'h002, 1'b0, 1'b0);
        hold(4);
        check("held_Do", 0, dout[0], 32'h01);
        check("held_valid", 0, v[0], 1);
        rdy[0] = 1'b1;
        occ[0] = 1'b0;
        hold(2);
        check("valid_cleared", 0, v[0], 0);

        // short low glitch while idle: no frame, receiver stays in idle
        ser[0] = 1'b0;
        hold(3);
        ser[0] = 1'b1;
        hold(12);
        check("glitch_busy", 0, bz[0], 0);
        send_frame(0, 9'h03A, 1'b0, 1'b0);
        hold(20);

        // reset in the middle of a frame
        fork
            drive_frame(0, 9'h0FF, 1'b0, 1'b0);
            begin
                hold(64);
                reset = 1'b1;
                model_reset();
                hold(1);
                reset = 1'b0;
                hold(2);
                check("rst_mid_valid", 0, v[0], 0);
                check("rst_mid_busy", 0, bz[0], 0);
            end
        join
        send_frame(0, 9'h012, 1'b0, 1'b0);
        idle(IDLE_T);
        send_frame(0, 9'h012, 1'b0, 1'b0);
        hold(4);

        // 7-bit, OVS 8: back to back
        send_frame(2, 9'h07F, 1'b0, 1'b0);
        send_frame(2, 9'h000, 1'b0, 1'b0);
        hold(4);

        // randomised frames on every configuration
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 12; k++) begin
                logic [8:0] d;
                bit         bp;
                d  = 9'($urandom);
                bp = (PAR[i] != 0) ? bit'($urandom_range(0, 1)) : 1'b0;
                send_frame(i, d, bp, 1'b0);
                hold($urandom_range(0, 3));
            end
        end

        // drain, bounded
        for (int k = 0; k < 2000; k++) begin
            if (expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size() == 0) break;
            @(negedge CLK);
        end
        hold(4);
        for (int i = 0; i < NI; i++) check("scoreboard_empty", i, expq[i].size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
